pc_fetch: RTL and testbench
===========================

# pc_fetch

IF-stage fetch unit: owns the fetch PC, issues word-aligned instruction requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions (with their PC) for the ID stage. It consumes the next-PC redirect produced in ID (taken branch, jump, jr/jalr, eret, exception entry) and discards every sequentially fetched instruction that the redirect invalidates.

## Interface
Parameters:
- RESET_PC, 30'h00000C00 (byte 0x3000), first word address fetched after reset.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  ID requests a PC change this cycle.
- redirect_pc  input  30  new word address [31:2], valid with redirect.
- id_ready  input  1  ID accepts the presented instruction.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- if_pc  output  30  word address [31:2] of presented instruction.
- if_instr  output  32  presented instruction.
- imem_req  output  1  fetch request.
- imem_addr  output  30  word address [31:2] of request.
- imem_gnt  input  1  request accepted this cycle (req && gnt).
- imem_rvalid  input  1  response valid; in order, exactly one per accepted request, latency ≥1 cycle, unbounded.
- imem_rdata  input  32  response data.

## Operation
- State: fetch_pc, head_pc, instruction buffer (DEPTH entries), outstanding counter (0..DEPTH), discard counter (0..DEPTH), FSM {BOOT, RUN}.
- BOOT: first cycle after rst deasserts; no request; → RUN unconditionally.
- RUN issue rule: imem_req=1 iff outstanding + occupancy < DEPTH and no redirect in progress this cycle; imem_addr=fetch_pc. On req&&gnt: fetch_pc ← fetch_pc+1 (30-bit wrap), outstanding+1.
- Once asserted, imem_req/imem_addr hold stable until gnt; only a redirect may withdraw or change them.
- Response: rvalid with discard>0 → discard−1, data dropped; else data pushed to buffer. Either way outstanding−1.
- Pop: if_valid && id_ready → head removed, head_pc ← head_pc+1.
- Redirect (highest priority): fetch_pc ← redirect_pc, head_pc ← redirect_pc, buffer flushed, discard ← outstanding (net of a same-cycle rvalid), any same-cycle gnt counted as outstanding and discarded. A same-cycle pop completes (head consumed) before the flush.
- if_valid = occupancy>0; if_pc = head_pc; if_instr = buffer head (0 when empty).
- Simultaneous push+pop on full buffer legal; occupancy unchanged.
- Redirect during BOOT applied; RUN starts at redirect_pc.
- rst mid-operation: all state cleared; late rvalid after reset is a protocol violation (memory is reset together).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_valid 0, if_pc RESET_PC, if_instr 0, counters 0, FSM BOOT.
- First request: imem_req=1 with RESET_PC in the 2nd cycle after rst deasserts.
- Redirect in cycle N → imem_req with redirect_pc in cycle N+1.
- rvalid in cycle M (not discarded) → if_valid in M+1. No combinational path rdata→if_instr.
- Sustained throughput with DEPTH=2 and 1-cycle memory: one instruction per cycle.

## Configuration
- PC_FETCH_BUF2_EN defined: DEPTH=2; two requests may be outstanding; full throughput.
- Undefined: DEPTH=1; one request or buffered instruction at a time; max one instruction every 2 cycles with 1-cycle memory. Redirect/discard rules unchanged.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning addr as data -> imem_addr 0xC00,0xC01,... ; if_pc/if_instr 0xC00,0xC01 consecutive with id_ready=1.
- id_ready=0 for 5 cycles -> imem_req drops once outstanding+occupancy=DEPTH; no instruction lost or duplicated; resume in order.
- redirect to 0x1060 with 2 outstanding (buffer2 build) -> both stale responses dropped; next if_pc 0x1060, then 0x1061.
- redirect with id_ready=1 and if_valid=1 same cycle -> head consumed once, remaining entry flushed, next if_pc = redirect_pc.
- gnt stalled low 4 cycles -> imem_addr stable; fetch_pc advances only on gnt.
- rst asserted mid-stream -> outputs at reset values immediately (async); restart fetch at 0xC00.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: IF-stage fetch unit. Owns the fetch PC, issues word-aligned
// requests over a req/gnt/rvalid handshake, buffers returned instructions
// with their PC for ID, and discards in-flight responses made stale by a
// redirect from ID.
// Build option: define PC_FETCH_BUF2_EN for a two-entry buffer (two
// outstanding requests, one instruction per cycle with 1-cycle memory);
// otherwise a single-entry buffer is used.
//
// state | meaning
// BOOT  | first cycle after reset release, no request issued
// RUN   | normal fetching
module pc_fetch #(
    parameter logic [29:0] RESET_PC = 30'h00000C00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [29:0] if_pc,
    output logic [31:0] if_instr,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

`ifdef PC_FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [29:0]   fetch_pc;
    logic [29:0]   head_pc;
    logic [31:0]   ibuf [DEPTH];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW:0]   used;
    logic          pop;
    logic          push;
    logic          drop;
    logic          accepted;

    function automatic logic ptr_inc(input logic p);
        return (DEPTH > 1) ? ~p : 1'b0;
    endfunction

    // Request credit counts the slot freed by a same-cycle pop so a
    // two-entry buffer sustains full rate; a redirect withdraws the request.
    always_comb begin
        pop             = (occ != '0) && id_ready;
        used            = {1'b0, outstanding} + {1'b0, occ} - {{CW{1'b0}}, pop};
        imem_req        = (state == RUN) && !redirect && (used < DEPTH_W);
        imem_addr       = fetch_pc;
        accepted        = imem_req && imem_gnt;
        drop            = imem_rvalid && (discard != '0);
        push            = imem_rvalid && !drop && !redirect;
        outstanding_nxt = outstanding + CW'(accepted) - CW'(imem_rvalid);
        if_valid        = (occ != '0);
        if_pc           = head_pc;
        if_instr        = if_valid ? ibuf[rd_ptr] : 32'h0;
    end

    // BOOT lasts exactly one cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= RUN;
        end
    end

    // Fetch and head PCs; a redirect (also during BOOT) overrides both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
        end else begin
            if (accepted) begin
                fetch_pc <= fetch_pc + 30'd1;
            end
            if (pop) begin
                head_pc <= head_pc + 30'd1;
            end
        end
    end

    // Every request still in flight at a redirect is stale, so the discard
    // count becomes the post-cycle outstanding count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                discard <= outstanding_nxt;
            end else if (drop) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Buffer pointers and occupancy; a redirect flushes after any pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect) begin
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // Instruction storage; registered so rdata never reaches if_instr
    // combinationally.
    always_ff @(posedge clk) begin
        if (push) begin
            ibuf[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized bench for pc_fetch with an in-order memory model
// and a queue-based reference of the instruction stream seen by ID.
module tb_pc_fetch;

`ifdef PC_FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [29:0] RST_PC = 30'h00000C00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [29:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [29:0] if_pc;
    logic [31:0] if_instr;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } mrsp_t;
    typedef struct {
        logic req; logic [29:0] addr; logic valid; logic [29:0] pc; logic [31:0] instr;
    } snap_t;

    int          checks = 0;
    int          errors = 0;
    mrsp_t       mq[$];
    logic [31:0] q[$];
    snap_t       log_q[$];
    int          out_cnt, disc, cyc;
    logic [29:0] exp_fetch, exp_head;
    bit          running;
    int          p_gnt, p_rv, p_ready, p_redir, min_lat, max_lat;
    bit          force_redir = 1'b0;
    logic [29:0] force_pc = '0;

    function automatic logic [31:0] memfn(input logic [29:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic bit chance(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // Called positioned at a negedge; one full cycle of stimulus, checking
    // and model update, returning at the next negedge.
    task automatic cycle();
        bit rsp, pop_e, exp_req, acc;
        int occ;
        logic [31:0] want_instr;
        redirect    = force_redir || chance(p_redir);
        redirect_pc = force_redir ? force_pc : 30'($urandom);
        id_ready    = chance(p_ready);
        imem_gnt    = chance(p_gnt);
        rsp = 1'b0;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) rsp = chance(p_rv);
        end
        imem_rvalid = rsp;
        imem_rdata  = rsp ? mq[0].data : $urandom;
        #1;
        occ        = q.size();
        pop_e      = (occ > 0) && id_ready;
        exp_req    = running && !redirect && (out_cnt + occ - int'(pop_e) < DEPTH);
        want_instr = (occ > 0) ? q[0] : 32'h0;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        check("if_valid", 32'(if_valid), 32'(occ > 0));
        check("if_pc", 32'(if_pc), 32'(exp_head));
        check("if_instr", if_instr, want_instr);
        log_q.push_back('{imem_req, imem_addr, if_valid, if_pc, if_instr});
        acc = exp_req && imem_gnt;
        if (rsp) void'(mq.pop_front());
        if (acc) mq.push_back('{memfn(imem_addr), cyc + 1 + min_lat + int'($urandom_range(max_lat - min_lat, 0))});
        if (redirect) begin
            q.delete();
            exp_fetch = redirect_pc;
            exp_head  = redirect_pc;
            out_cnt   = out_cnt + int'(acc) - int'(rsp);
            disc      = out_cnt;
        end else begin
            if (acc) exp_fetch = exp_fetch + 30'd1;
            if (pop_e) begin
                void'(q.pop_front());
                exp_head = exp_head + 30'd1;
            end
            if (rsp) begin
                if (disc > 0) disc--;
                else q.push_back(imem_rdata);
            end
            out_cnt = out_cnt + int'(acc) - int'(rsp);
        end
        running = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_knobs(input int g, input int rv, input int rd, input int rr,
                             input int lo, input int hi);
        p_gnt = g; p_rv = rv; p_ready = rd; p_redir = rr; min_lat = lo; max_lat = hi;
    endtask

    // Called positioned at a negedge; asserts reset asynchronously, checks
    // outputs immediately, releases it at a later negedge.
    task automatic do_reset();
        redirect = 1'b0; id_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        force_redir = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", 32'(imem_addr), 32'h00000C00);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc", 32'(if_pc), 32'h00000C00);
        check("rst_if_instr", if_instr, 32'h0);
        mq.delete(); q.delete(); log_q.delete();
        out_cnt = 0; disc = 0; cyc = 0; running = 1'b0;
        exp_fetch = RST_PC; exp_head = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int idx, found, n;
        set_knobs(100, 100, 100, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Reset release, always-grant, 1-cycle memory, ID always ready.
        run(12);
        check("boot_no_req", 32'(log_q[0].req), 32'h0);
        check("first_req", 32'(log_q[1].req), 32'h1);
        check("first_addr", 32'(log_q[1].addr), 32'h00000C00);
        check("first_valid", 32'(log_q[3].valid), 32'h1);
        check("first_pc", 32'(log_q[3].pc), 32'h00000C00);
        check("first_instr", log_q[3].instr, 32'hF3FF0C00);
`ifdef PC_FETCH_BUF2_EN
        check("second_addr", 32'(log_q[2].addr), 32'h00000C01);
        check("second_pc", 32'(log_q[4].pc), 32'h00000C01);
        check("second_instr", log_q[4].instr, 32'hF3FE0C01);
        check("rate_valid", 32'(log_q[8].valid), 32'h1);
        check("rate_pc", 32'(log_q[8].pc), 32'h00000C05);
`else
        check("second_addr", 32'(log_q[3].addr), 32'h00000C01);
        check("gap_valid", 32'(log_q[4].valid), 32'h0);
        check("second_pc", 32'(log_q[5].pc), 32'h00000C01);
        check("second_instr", log_q[5].instr, 32'hF3FE0C01);
        check("rate_pc", 32'(log_q[9].pc), 32'h00000C03);
`endif

        // ID stalls for 5 cycles: requests must stop once the buffer is committed.
        set_knobs(100, 100, 0, 0, 0, 0);
        run(5);
        check("stall_req_off", 32'(log_q[log_q.size() - 1].req), 32'h0);
        set_knobs(100, 100, 100, 0, 0, 0);
        run(10);

        // Grant held low for 4 cycles.
        set_knobs(0, 100, 100, 0, 0, 0);
        run(4);
        check("gnt_stall_req", 32'(log_q[log_q.size() - 1].req), 32'h1);
        set_knobs(100, 100, 100, 0, 0, 0);
        run(6);

        // Redirect to 0x1060 with the buffer's worth of requests in flight.
        set_knobs(100, 100, 100, 0, 3, 3);
        n = 0;
        while (out_cnt < DEPTH && n < 20) begin cycle(); n++; end
        if (out_cnt < DEPTH) bound_fail("fill_outstanding");
        force_redir = 1'b1; force_pc = 30'h00001060;
        cycle();
        force_redir = 1'b0;
        set_knobs(100, 100, 100, 0, 0, 0);
        idx = log_q.size();
        run(20);
        found = -1;
        for (int i = idx; i < log_q.size(); i++) begin
            if (found < 0 && log_q[i].valid) found = i;
        end
        if (found < 0) bound_fail("redirect_first_valid");
        else begin
            check("redir_pc0", 32'(log_q[found].pc), 32'h00001060);
            check("redir_instr0", log_q[found].instr, 32'hEF9F1060);
            idx = -1;
            for (int i = found + 1; i < log_q.size(); i++) begin
                if (idx < 0 && log_q[i].valid && log_q[i].pc != log_q[found].pc) idx = i;
            end
            if (idx < 0) bound_fail("redirect_second_valid");
            else begin
                check("redir_pc1", 32'(log_q[idx].pc), 32'h00001061);
                check("redir_instr1", log_q[idx].instr, 32'hEF9E1061);
            end
        end

        // Reset mid-stream, then fetch restarts at the reset PC.
        set_knobs(80, 80, 80, 5, 0, 2);
        run(30);
        do_reset();
        set_knobs(100, 100, 100, 0, 0, 0);
        run(5);
        check("restart_req", 32'(log_q[1].req), 32'h1);
        check("restart_addr", 32'(log_q[1].addr), 32'h00000C00);

        // Randomized rounds with varying grant/latency/ready/redirect rates.
        for (int r = 0; r < 8; r++) begin
            set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 20)), int'($urandom_range(12, 0)),
                      0, int'($urandom_range(4, 0)));
            run(400);
            if (r % 3 == 2) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
